// File: rtl/hexaram_ctrl_if.sv
// hexaram_ctrl_if: client request/grant bus and memory port bundle for hexaram_ctrl
interface hexaram_ctrl_if #(parameter int W = 8);
  logic [3:0] wr_req, wr_gnt;
  logic [4*W-1:0] wr_addr, wr_data;
  logic [5:0] rd_req, rd_gnt, rd_vld;
  logic [6*W-1:0] rd_addr, rd_q;
  logic [W-1:0] data_a, data_b;
  logic [W-1:0] addr_a, addr_b, addr_c, addr_d, addr_e, addr_f;
  logic [W-1:0] q_a, q_b, q_c, q_d, q_e, q_f;
  logic we_a, we_b;
  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, q_a, q_b, q_c, q_d, q_e, q_f,
    input wr_gnt, rd_gnt, rd_vld, rd_q, data_a, data_b, we_a, we_b,
    input addr_a, addr_b, addr_c, addr_d, addr_e, addr_f
  );
  modport slave (
    input wr_req, wr_addr, wr_data, rd_req, rd_addr, q_a, q_b, q_c, q_d, q_e, q_f,
    output wr_gnt, rd_gnt, rd_vld, rd_q, data_a, data_b, we_a, we_b,
    output addr_a, addr_b, addr_c, addr_d, addr_e, addr_f
  );
endinterface

// File: rtl/hexaram_ctrl.sv
// hexaram_ctrl: round-robin write / blocked-read scheduler with per-side starvation guard
module hexaram_ctrl #(
  parameter int W = 8,
  parameter int STARVE = 4
) (
  input logic clk,
  input logic rst,
  hexaram_ctrl_if.slave bus
);
  logic [1:0] ptr, fi, si, idx, ga, gb;
  logic fv, sv, ga_v, gb_v, hold_a, hold_b, blk_a, blk_b;
  logic [3:0] cnt_a, cnt_b;
  logic [W-1:0] wa, wb;
  logic [W-1:0] held [6];
  logic [W-1:0] raddr [6];
  always_comb begin
    fv = 1'b0;
    sv = 1'b0;
    fi = '0;
    si = '0;
    idx = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (bus.wr_req[idx] && !rst) begin
        if (!fv) begin
          fv = 1'b1;
          fi = idx;
        end else if (!sv) begin
          sv = 1'b1;
          si = idx;
        end
      end
    end
  end
  // A held side A passes its first candidate on to port b
  assign ga = fi;
  assign ga_v = fv & ~hold_a;
  assign gb = hold_a ? fi : si;
  assign gb_v = hold_a ? fv & ~hold_b
                       : sv & ~hold_b & (bus.wr_addr[si*W +: W] != bus.wr_addr[fi*W +: W]);
  assign wa = bus.wr_addr[ga*W +: W];
  assign wb = bus.wr_addr[gb*W +: W];
  assign bus.wr_gnt = (ga_v ? 4'b1 << ga : 4'b0) | (gb_v ? 4'b1 << gb : 4'b0);
  assign bus.we_a = ga_v;
  assign bus.we_b = gb_v;
  assign bus.data_a = bus.wr_data[ga*W +: W];
  assign bus.data_b = bus.wr_data[gb*W +: W];
  assign bus.rd_gnt = bus.rd_req & ~{3{gb_v, ga_v}} & {6{~rst}};
  always_comb begin
    for (int i = 0; i < 6; i++) raddr[i] = bus.rd_gnt[i] ? bus.rd_addr[i*W +: W] : held[i];
  end
  // A writing side forces its write address onto every port of that side
  assign bus.addr_a = ga_v ? wa : raddr[0];
  assign bus.addr_b = gb_v ? wb : raddr[1];
  assign bus.addr_c = ga_v ? wa : raddr[2];
  assign bus.addr_d = gb_v ? wb : raddr[3];
  assign bus.addr_e = ga_v ? wa : raddr[4];
  assign bus.addr_f = gb_v ? wb : raddr[5];
  assign bus.rd_q = {bus.q_f, bus.q_e, bus.q_d, bus.q_c, bus.q_b, bus.q_a};
  assign blk_a = ga_v & |(bus.rd_req & 6'b010101);
  assign blk_b = gb_v & |(bus.rd_req & 6'b101010);
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      hold_a <= 1'b0;
      hold_b <= 1'b0;
      bus.rd_vld <= '0;
      for (int i = 0; i < 6; i++) held[i] <= '0;
    end else begin
      bus.rd_vld <= bus.rd_gnt;
      for (int i = 0; i < 6; i++) if (bus.rd_gnt[i]) held[i] <= bus.rd_addr[i*W +: W];
      if (ga_v || gb_v) ptr <= (gb_v ? gb : ga) + 2'd1;
      // A hold lasts one cycle: every pending read on that side is granted during it
      if (hold_a) begin
        hold_a <= 1'b0;
        cnt_a <= '0;
      end else if (blk_a) begin
        cnt_a <= cnt_a + 4'd1;
        hold_a <= (cnt_a + 4'd1) == 4'(STARVE);
      end else cnt_a <= '0;
      if (hold_b) begin
        hold_b <= 1'b0;
        cnt_b <= '0;
      end else if (blk_b) begin
        cnt_b <= cnt_b + 4'd1;
        hold_b <= (cnt_b + 4'd1) == 4'(STARVE);
      end else cnt_b <= '0;
    end
  end
endmodule
